// File: rtl/clock_set_ctrl_pkg.sv
// Shared constants for the six-digit clock: mode encoding, BCD field maxima
// and the per-mode blank mask for the field being edited.
package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;
    localparam logic [1:0] MODE_SET_SEC = 2'd3;

    localparam logic [3:0] HR_MAX_T = 4'd2;
    localparam logic [3:0] HR_MAX_U = 4'd3;
    localparam logic [3:0] MS_MAX_T = 4'd5;
    localparam logic [3:0] MS_MAX_U = 4'd9;

    // Digit pair of the field edited in a given mode (bit i = digit i).
    function automatic logic [5:0] field_mask(input logic [1:0] mode);
        logic [5:0] m;
        case (mode)
            MODE_SET_HR:  m = 6'b110000;
            MODE_SET_MIN: m = 6'b001100;
            MODE_SET_SEC: m = 6'b000011;
            default:      m = 6'b000000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button inputs and display outputs of the clock controller.
// slave: the controller; master: whatever drives buttons and reads the display.
interface clock_set_ctrl_if;

    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] dig4;
    logic [3:0] dig5;
    logic [5:0] blank;
    logic [1:0] mode;
    logic       sec_tick;

    modport master (
        output btn_mode, btn_inc, btn_dec,
        input  dig0, dig1, dig2, dig3, dig4, dig5, blank, mode, sec_tick
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec,
        output dig0, dig1, dig2, dig3, dig4, dig5, blank, mode, sec_tick
    );

endinterface

// File: rtl/clock_set_ctrl_bcd2_counter.sv
// Two-digit BCD up/down counter wrapping at MAX_T:MAX_U <-> 00.
// carry_o is combinational so a downstream field updates on the same edge.
module bcd2_counter #(
    parameter logic [3:0] MAX_T = 4'd5,
    parameter logic [3:0] MAX_U = 4'd9
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_up_i,
    input  logic       en_down_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       carry_o
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       up, down, at_max, at_zero;

    assign up      = en_up_i && !en_down_i;
    assign down    = en_down_i && !en_up_i;
    assign at_max  = (tens_q == MAX_T) && (units_q == MAX_U);
    assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);

    // Next value: pure digit arithmetic, units roll 9<->0 into the tens digit.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (up) begin
            if (at_max) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end else if (down) begin
            if (at_zero) begin
                tens_d  = MAX_T;
                units_d = MAX_U;
            end else if (units_q == 4'd0) begin
                tens_d  = tens_q - 4'd1;
                units_d = 4'd9;
            end else begin
                units_d = units_q - 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens_o  = tens_q;
    assign units_o = units_q;
    assign carry_o = up && at_max;

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM:SS BCD clock with 1 Hz prescaler and button-driven set mode.
// Optional field blinking while editing: define CLOCK_BLINK_EN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    clock_set_ctrl_if.slave  bus
);

    localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    if (CLK_HZ < 2 || BLINK_DIV < 1) begin : g_bad_params
        $error("clock_set_ctrl: CLK_HZ must be >= 2 and BLINK_DIV >= 1");
    end

    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          run, tick, acc_inc, acc_dec;
    logic          sec_up, sec_dn, min_up, min_dn, hr_up, hr_dn;
    logic          sec_carry, min_carry, hr_carry;
    logic [3:0]    sec_t, sec_u, min_t, min_u, hr_t, hr_u;

    assign run     = (mode_q == MODE_RUN);
    assign tick    = run && (presc_q == PRESC_LAST);
    // Edits only in a set mode, and only when unambiguous.
    assign acc_inc = !run && bus.btn_inc && !bus.btn_dec && !bus.btn_mode;
    assign acc_dec = !run && bus.btn_dec && !bus.btn_inc && !bus.btn_mode;

    // Carries propagate only in RUN; edits never spill into another field.
    assign sec_up = tick || ((mode_q == MODE_SET_SEC) && acc_inc);
    assign sec_dn = (mode_q == MODE_SET_SEC) && acc_dec;
    assign min_up = (run && sec_carry) || ((mode_q == MODE_SET_MIN) && acc_inc);
    assign min_dn = (mode_q == MODE_SET_MIN) && acc_dec;
    assign hr_up  = (run && min_carry) || ((mode_q == MODE_SET_HR) && acc_inc);
    assign hr_dn  = (mode_q == MODE_SET_HR) && acc_dec;

    // Mode sequencing and prescaler; prescaler is parked at 0 outside RUN.
    always_comb begin
        mode_d = mode_q;
        if (bus.btn_mode) begin
            case (mode_q)
                MODE_RUN:     mode_d = MODE_SET_HR;
                MODE_SET_HR:  mode_d = MODE_SET_MIN;
                MODE_SET_MIN: mode_d = MODE_SET_SEC;
                default:      mode_d = MODE_RUN;
            endcase
        end
        presc_d = presc_q + 1'b1;
        if (!run || bus.btn_mode || tick) begin
            presc_d = '0;
        end
    end

    // Mode and prescaler registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_RUN;
            presc_q <= '0;
        end else begin
            mode_q  <= mode_d;
            presc_q <= presc_d;
        end
    end

    bcd2_counter #(.MAX_T(MS_MAX_T), .MAX_U(MS_MAX_U)) u_sec (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_up_i   (sec_up),
        .en_down_i (sec_dn),
        .tens_o    (sec_t),
        .units_o   (sec_u),
        .carry_o   (sec_carry)
    );

    bcd2_counter #(.MAX_T(MS_MAX_T), .MAX_U(MS_MAX_U)) u_min (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_up_i   (min_up),
        .en_down_i (min_dn),
        .tens_o    (min_t),
        .units_o   (min_u),
        .carry_o   (min_carry)
    );

    bcd2_counter #(.MAX_T(HR_MAX_T), .MAX_U(HR_MAX_U)) u_hr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_up_i   (hr_up),
        .en_down_i (hr_dn),
        .tens_o    (hr_t),
        .units_o   (hr_u),
        .carry_o   (hr_carry)
    );

    assign bus.dig0     = sec_u;
    assign bus.dig1     = sec_t;
    assign bus.dig2     = min_u;
    assign bus.dig3     = min_t;
    assign bus.dig4     = hr_u;
    assign bus.dig5     = hr_t;
    assign bus.mode     = mode_q;
    assign bus.sec_tick = tick;

`ifdef CLOCK_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          unused_hr_carry;

    assign unused_hr_carry = hr_carry;

    // Blink phase runs only while editing; mode changes and edits restart it visible.
    always_comb begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (run || bus.btn_mode || acc_inc || acc_dec) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = !phase_q;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign bus.blank = phase_q ? field_mask(mode_q) : 6'b000000;
`else
    logic unused_hr_carry;

    assign unused_hr_carry = hr_carry;
    assign bus.blank       = 6'b000000;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl (CLK_HZ=10, BLINK_DIV=4).
// Blink checks are compiled in when CLOCK_BLINK_EN is defined.
module tb_clock_set_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int BLINK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_DIV(BLINK_DIV)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integer time and counters.
    int m_h, m_m, m_s, m_mode, m_presc, m_bcnt, m_phase;

    typedef struct {
        logic bm;
        logic bi;
        logic bd;
        int   mode;
        int   h;
        int   m;
        int   s;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] model_blank();
`ifdef CLOCK_BLINK_EN
        if (m_phase == 0) return 6'b000000;
        case (m_mode)
            1:       return 6'b110000;
            2:       return 6'b001100;
            3:       return 6'b000011;
            default: return 6'b000000;
        endcase
`else
        return 6'b000000;
`endif
    endfunction

    function automatic logic [32:0] model_vec();
        logic tk;
        tk = (m_mode == 0) && (m_presc == CLK_HZ - 1);
        return {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
                4'(m_s / 10), 4'(m_s % 10), 2'(m_mode), tk, model_blank()};
    endfunction

    function automatic logic [32:0] dut_vec();
        return {bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0,
                bus.mode, bus.sec_tick, bus.blank};
    endfunction

    function automatic logic [23:0] bcd_time(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] dut_time();
        return {bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0};
    endfunction

    task automatic model_step(input logic r, input logic bm, input logic bi, input logic bd);
        logic tk, ai, ad;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_presc = 0; m_bcnt = 0; m_phase = 0;
            return;
        end
        tk = (m_mode == 0) && (m_presc == CLK_HZ - 1);
        ai = (m_mode != 0) && bi && !bd && !bm;
        ad = (m_mode != 0) && bd && !bi && !bm;
        if (tk) begin
            m_s = m_s + 1;
            if (m_s == 60) begin
                m_s = 0;
                m_m = m_m + 1;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h = (m_h + 1) % 24;
                end
            end
        end
        m_presc = (m_mode != 0 || bm || tk) ? 0 : m_presc + 1;
        case (m_mode)
            1: begin if (ai) m_h = (m_h + 1) % 24; if (ad) m_h = (m_h + 23) % 24; end
            2: begin if (ai) m_m = (m_m + 1) % 60; if (ad) m_m = (m_m + 59) % 60; end
            3: begin if (ai) m_s = (m_s + 1) % 60; if (ad) m_s = (m_s + 59) % 60; end
            default: ;
        endcase
        if (m_mode == 0 || bm || ai || ad) begin
            m_bcnt  = 0;
            m_phase = 0;
        end else if (m_bcnt == BLINK_DIV - 1) begin
            m_bcnt  = 0;
            m_phase = 1 - m_phase;
        end else begin
            m_bcnt = m_bcnt + 1;
        end
        if (bm) m_mode = (m_mode + 1) % 4;
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare everything.
    task automatic step(input logic r, input logic bm, input logic bi, input logic bd);
        rst          = r;
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        bus.btn_dec  = bd;
        @(posedge clk);
        #1;
        model_step(r, bm, bi, bd);
        rst          = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        check("model", 64'(dut_vec()), 64'(model_vec()));
    endtask

    initial begin
        int tick_cnt, first_tick, second_tick;

        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        @(negedge clk);

        // Reset held two cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_state", 64'(dut_vec()), 64'(0));

        // Set 23:59:58 with wraps and simultaneous-button cases on the way.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1, 23, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1, 23, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 2, 23, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2, 23, 59, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2, 23, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2, 23, 59, 0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3, 23, 59, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3, 23, 59, 59};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3, 23, 59, 58};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 0, 23, 59, 58};
        for (int i = 0; i < 13; i++) begin
            step(1'b0, tbl[i].bm, tbl[i].bi, tbl[i].bd);
            check($sformatf("tbl%0d_mode", i), 64'(bus.mode), 64'(tbl[i].mode));
            check($sformatf("tbl%0d_time", i), 64'(dut_time()),
                  64'(bcd_time(tbl[i].h, tbl[i].m, tbl[i].s)));
        end

        // Run 20 cycles: ticks 10 apart, full carry to 00:00:00.
        tick_cnt    = 0;
        first_tick  = -1;
        second_tick = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
            if (bus.sec_tick === 1'b1) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = k;
                else if (second_tick < 0) second_tick = k;
            end
        end
        check("run_tick_count", 64'(tick_cnt), 64'(2));
        check("run_first_tick", 64'(first_tick), 64'(9));
        check("run_tick_spacing", 64'(second_tick - first_tick), 64'(10));
        check("run_wrap_time", 64'(dut_time()), 64'(bcd_time(0, 0, 0)));

`ifdef CLOCK_BLINK_EN
        // Blink in SET_MIN: 4 visible, 4 blanked; an edit restarts visible.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("blink_s0", 64'(bus.blank), 64'(0));
        for (int s = 1; s <= 13; s++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("blink_s%0d", s), 64'(bus.blank),
                  64'(((s / 4) % 2 == 1) ? 6'b001100 : 6'b000000));
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("blink_inc_clear", 64'(bus.blank), 64'(0));
        for (int s = 1; s <= 4; s++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("blink_after_inc%0d", s), 64'(bus.blank),
                  64'((s == 4) ? 6'b001100 : 6'b000000));
        end
`endif

        // Reset from SET_SEC at 12:34:56; prescaler must restart from zero.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 56; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("set_sec_time", 64'(dut_time()), 64'(bcd_time(12, 34, 56)));
        check("set_sec_mode", 64'(bus.mode), 64'(3));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_set_mode", 64'(bus.mode), 64'(0));
        check("rst_set_time", 64'(dut_time()), 64'(bcd_time(0, 0, 0)));
        first_tick = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.sec_tick === 1'b1 && first_tick < 0) first_tick = k;
        end
        check("rst_first_tick", 64'(first_tick), 64'(9));
        check("rst_one_sec", 64'(dut_time()), 64'(bcd_time(0, 0, 1)));

        // Randomized buttons against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
